// File: rtl/instr_decode_ctrl.sv
// Decode/sequencing stage ahead of the ALU/register-file block: accepts one instruction per
// handshake, runs a fixed IDLE->READ->EXEC cycle and keeps the PSR that feeds carry back in.
module instr_decode_ctrl #(
    parameter int              DATA_W   = 16,
    parameter int              SEL_W    = 5,
    parameter logic [SEL_W-1:0] NO_WRITE = 5'd31
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [4:0]        flagsOutput,
    output logic [DATA_W-1:0] immediate,
    output logic [SEL_W-1:0]  regEnables,
    output logic [SEL_W-1:0]  buffAEnables,
    output logic [SEL_W-1:0]  buffBEnables,
    output logic              Cin,
    output logic              regOrImmed,
    output logic [3:0]        op,
    output logic [3:0]        exop,
    output logic [4:0]        flags,
    output logic              retire
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2
    } state_t;

    localparam logic [3:0] OP_REG  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0101;
    localparam logic [3:0] OP_ADDC = 4'b0111;
    localparam logic [3:0] OP_SUBI = 4'b1001;
    localparam logic [3:0] OP_SUBC = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;
    localparam logic [3:0] OP_LUI  = 4'b1111;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [4:0]        psr_q, psr_d;

    logic              instr_ready_q, instr_ready_d;
    logic [DATA_W-1:0] immediate_q, immediate_d;
    logic [SEL_W-1:0]  reg_en_q, reg_en_d;
    logic [SEL_W-1:0]  buff_a_q, buff_a_d;
    logic [SEL_W-1:0]  buff_b_q, buff_b_d;
    logic              cin_q, cin_d;
    logic              reg_or_immed_q, reg_or_immed_d;
    logic [3:0]        op_q, op_d;
    logic [3:0]        exop_q, exop_d;
    logic              retire_q, retire_d;

    logic [3:0]        cur_class;
    logic [3:0]        nxt_opcode;
    logic [3:0]        nxt_class;
    logic [7:0]        nxt_imm8;

    // Class code selects flag/carry/no-write behaviour: exop for register form, opcode otherwise.
    function automatic logic [3:0] class_of(input logic [DATA_W-1:0] ins);
        return (ins[15:12] == OP_REG) ? ins[7:4] : ins[15:12];
    endfunction

    function automatic logic is_flag_class(input logic [3:0] code);
        return (code == 4'b0101) || (code == 4'b0110) || (code == 4'b0111) ||
               (code == 4'b1001) || (code == 4'b1010) || (code == 4'b1011);
    endfunction

    assign cur_class = class_of(instr_q);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        psr_d   = psr_q;
        case (state_q)
            IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    instr_d = instr;
                    state_d = READ;
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
                state_d = IDLE;
                if (is_flag_class(cur_class)) begin
                    psr_d = flagsOutput;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign nxt_opcode = instr_d[15:12];
    assign nxt_class  = class_of(instr_d);
    assign nxt_imm8   = instr_d[7:0];

    // Outputs are decoded for the state being entered so they are stable for the whole cycle
    // straight out of flops; Cin reads the PSR as it stands, i.e. before this instruction's capture.
    always_comb begin
        instr_ready_d  = (state_d == IDLE);
        retire_d       = (state_d == EXEC);
        immediate_d    = '0;
        reg_en_d       = NO_WRITE;
        buff_a_d       = '0;
        buff_b_d       = '0;
        cin_d          = 1'b0;
        reg_or_immed_d = 1'b0;
        op_d           = 4'b0000;
        exop_d         = 4'b0000;
        if (state_d != IDLE) begin
            buff_a_d = {{(SEL_W-4){1'b0}}, instr_d[11:8]};
            buff_b_d = {{(SEL_W-4){1'b0}}, instr_d[3:0]};
            if (nxt_opcode == OP_REG) begin
                exop_d         = instr_d[7:4];
                reg_or_immed_d = 1'b1;
            end else begin
                op_d = nxt_opcode;
                case (nxt_opcode)
                    OP_ADDI, OP_SUBI, OP_CMP:
                        immediate_d = {{(DATA_W-8){nxt_imm8[7]}}, nxt_imm8};
                    OP_LUI:
                        immediate_d = {nxt_imm8, {(DATA_W-8){1'b0}}};
                    default:
                        immediate_d = {{(DATA_W-8){1'b0}}, nxt_imm8};
                endcase
            end
            if ((nxt_class == OP_ADDC) || (nxt_class == OP_SUBC)) begin
                cin_d = psr_q[4];
            end
            if ((state_d == EXEC) && (nxt_class != OP_CMP)) begin
                reg_en_d = {{(SEL_W-4){1'b0}}, instr_d[11:8]};
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            instr_q        <= '0;
            psr_q          <= '0;
            instr_ready_q  <= 1'b1;
            immediate_q    <= '0;
            reg_en_q       <= NO_WRITE;
            buff_a_q       <= '0;
            buff_b_q       <= '0;
            cin_q          <= 1'b0;
            reg_or_immed_q <= 1'b0;
            op_q           <= 4'b0000;
            exop_q         <= 4'b0000;
            retire_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            psr_q          <= psr_d;
            instr_ready_q  <= instr_ready_d;
            immediate_q    <= immediate_d;
            reg_en_q       <= reg_en_d;
            buff_a_q       <= buff_a_d;
            buff_b_q       <= buff_b_d;
            cin_q          <= cin_d;
            reg_or_immed_q <= reg_or_immed_d;
            op_q           <= op_d;
            exop_q         <= exop_d;
            retire_q       <= retire_d;
        end
    end

    assign instr_ready  = instr_ready_q;
    assign immediate    = immediate_q;
    assign regEnables   = reg_en_q;
    assign buffAEnables = buff_a_q;
    assign buffBEnables = buff_b_q;
    assign Cin          = cin_q;
    assign regOrImmed   = reg_or_immed_q;
    assign op           = op_q;
    assign exop         = exop_q;
    assign flags        = psr_q;
    assign retire       = retire_q;

endmodule
